// File: rtl/if_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and instruction memory (slave).
// Requests use a req/gnt handshake; read data returns in order with rvalid.
interface if_fetch_unit_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemGnt;
  logic        imemRvalid;
  logic [31:0] imemRdata;

  modport master (
    output imemReq,
    output imemAddr,
    input  imemGnt,
    input  imemRvalid,
    input  imemRdata
  );

  modport slave (
    input  imemReq,
    input  imemAddr,
    output imemGnt,
    output imemRvalid,
    output imemRdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// IF-stage fetch engine: issues sequential PCs to instruction memory and buffers the
// returned words in an in-order queue that feeds the IF/ID register, with NOPs when empty.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_stall,
  input  logic                   i_redirect,
  input  logic [31:0]            i_redirectPc,
  if_fetch_unit_if.master        bus,
  output logic [31:0]            o_pcOut,
  output logic [31:0]            o_instrOut,
  output logic                   o_validOut
);
  localparam int          CW  = $clog2(DEPTH + 1);
  localparam int          PW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_fetchPc;
  logic [31:0]   r_respPc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_dropCnt;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_rdPtr;
  logic [PW-1:0] r_wrPtr;
  logic [31:0]   r_qPc    [DEPTH];
  logic [31:0]   r_qInstr [DEPTH];

  logic          w_valid;
  logic          w_pop;
  logic [CW:0]   w_inUse;
  logic          w_req;
  logic          w_grant;
  logic          w_resp;
  logic          w_drop;
  logic          w_push;

  // Queued plus in-flight words may never exceed DEPTH, so a push never finds the queue full.
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & ~i_stall & ~i_redirect;
  assign w_inUse = {1'b0, r_count} + {1'b0, r_outstanding} - (CW+1)'(w_pop);
  assign w_req   = ~rst & ~i_redirect & (w_inUse < (CW+1)'(DEPTH));
  assign w_grant = w_req & bus.imemGnt;
  assign w_resp  = bus.imemRvalid & (r_outstanding != '0);
  assign w_drop  = w_resp & (r_dropCnt != '0);
  assign w_push  = w_resp & ~w_drop & ~i_redirect;

  assign bus.imemReq  = w_req;
  assign bus.imemAddr = r_fetchPc;
  assign o_validOut   = w_valid;
  assign o_pcOut      = w_valid ? r_qPc[r_rdPtr]    : 32'h0;
  assign o_instrOut   = w_valid ? r_qInstr[r_rdPtr] : NOP;

  // On redirect every response still in flight belongs to the old path and must be dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetchPc     <= RESET_PC;
      r_respPc      <= RESET_PC;
      r_outstanding <= '0;
      r_dropCnt     <= '0;
      r_count       <= '0;
      r_rdPtr       <= '0;
      r_wrPtr       <= '0;
    end else if (i_redirect) begin
      r_fetchPc     <= {i_redirectPc[31:2], 2'b00};
      r_respPc      <= {i_redirectPc[31:2], 2'b00};
      r_outstanding <= r_outstanding - CW'(w_resp);
      r_dropCnt     <= r_outstanding - CW'(w_resp);
      r_count       <= '0;
      r_rdPtr       <= '0;
      r_wrPtr       <= '0;
    end else begin
      if (w_grant) begin
        r_fetchPc <= r_fetchPc + 32'd4;
      end
      r_outstanding <= r_outstanding + CW'(w_grant) - CW'(w_resp);
      if (w_drop) begin
        r_dropCnt <= r_dropCnt - CW'(1);
      end
      if (w_push) begin
        r_wrPtr  <= r_wrPtr + PW'(1);
        r_respPc <= r_respPc + 32'd4;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push & ~rst) begin
      r_qPc[r_wrPtr]    <= r_respPc;
      r_qInstr[r_wrPtr] <= bus.imemRdata;
    end
  end
endmodule
